// File: rtl/dht_poll_scheduler.sv
// Purpose : schedules DHT-sensor reads (periodic + manual), retries failed frames, publishes last good values.
// Latency : rd_start follows a request once the inter-read gap has elapsed; upd/fail pulse 1 cycle after CHECK/attempt end.
// Backpres: none; requests coalesce into one pending flag, rd_done outside WAIT_DONE is dropped.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   req_manual      - single-cycle read request
//   rd_start        - single-cycle reader trigger
//   rd_done/rd_data - frame-complete strobe and 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
//   temp, humidity  - last good temperature / humidity integer bytes
//   valid           - at least one good frame since reset
//   upd, fail       - single-cycle new-value / retries-exhausted strobes
//   err_count       - exhausted-sequence counter, saturating at 255
//   busy            - sequence in progress (FSM not in IDLE)
// Build option: define DHT_CHECKSUM_EN to verify the frame checksum; otherwise every
// received frame is accepted and only timeouts cause retries.

module dht_poll_scheduler #(
    parameter int PERIOD_CYC  = 100_000_000,
    parameter int MIN_GAP_CYC = 50_000_000,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_manual,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic [39:0] rd_data,
    output logic [7:0]  temp,
    output logic [7:0]  humidity,
    output logic        valid,
    output logic        upd,
    output logic        fail,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int PW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam int GW = (MIN_GAP_CYC > 0) ? $clog2(MIN_GAP_CYC + 1) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_GAP_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GAP,
        START,
        WAIT_DONE,
        CHECK,
        UPDATE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_per_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic [RW-1:0]   r_retry;
    logic            r_pending;

    logic            r_rd_start;
    logic [7:0]      r_temp;
    logic [7:0]      r_hum;
    logic            r_valid;
    logic            r_upd;
    logic            r_fail;
    logic [7:0]      r_err;
    logic            r_busy;

    // Bytes of the captured frame that UPDATE needs.
    logic [7:0]      r_cap_hum;
    logic [7:0]      r_cap_temp;

    logic            w_req;
    logic            w_pass;
    logic            w_attempt_fail;

    assign w_req = req_manual | (r_per_cnt == PER_LAST);

`ifdef DHT_CHECKSUM_EN
    logic [7:0]      r_cap_hdec;
    logic [7:0]      r_cap_tdec;
    logic [7:0]      r_cap_ck;
    logic [7:0]      w_sum;

    // 8-bit sum: carries out of the byte are discarded, i.e. mod 256.
    assign w_sum  = r_cap_hum + r_cap_hdec + r_cap_temp + r_cap_tdec;
    assign w_pass = (w_sum == r_cap_ck);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_hdec <= 8'd0;
            r_cap_tdec <= 8'd0;
            r_cap_ck   <= 8'd0;
        end else if (r_state == WAIT_DONE && rd_done) begin
            r_cap_hdec <= rd_data[31:24];
            r_cap_tdec <= rd_data[15:8];
            r_cap_ck   <= rd_data[7:0];
        end
    end
`else
    // Without checksum checking the decimal and checksum bytes are never consumed.
    logic w_unused_bytes;
    assign w_unused_bytes = ^{rd_data[31:24], rd_data[15:0]};
    assign w_pass         = 1'b1;
`endif

    // A failed attempt is either a timeout with no frame this cycle (rd_done wins a tie)
    // or a frame rejected by CHECK.
    assign w_attempt_fail = ((r_state == WAIT_DONE) && !rd_done && (r_tmo_cnt == TMO_LAST))
                          || ((r_state == CHECK) && !w_pass);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_per_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_retry    <= '0;
            r_pending  <= 1'b0;
            r_rd_start <= 1'b0;
            r_temp     <= 8'd0;
            r_hum      <= 8'd0;
            r_valid    <= 1'b0;
            r_upd      <= 1'b0;
            r_fail     <= 1'b0;
            r_err      <= 8'd0;
            r_busy     <= 1'b0;
            r_cap_hum  <= 8'd0;
            r_cap_temp <= 8'd0;
        end else begin
            r_rd_start <= 1'b0;
            r_upd      <= 1'b0;
            r_fail     <= 1'b0;

            // Free-running period counter; its terminal count raises a request.
            if (r_per_cnt == PER_LAST) begin
                r_per_cnt <= '0;
            end else begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end

            // Time since the last reader trigger, held once the minimum gap is reached.
            // Starting from 0 at reset also gives the sensor its power-up settling time.
            if (r_rd_start) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != GAP_MAX) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            // Single pending flag: a request landing on the consume cycle is absorbed
            // by the sequence that is just starting.
            if (r_state == IDLE && r_pending) begin
                r_pending <= 1'b0;
            end else if (w_req) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        r_state <= WAIT_GAP;
                        r_busy  <= 1'b1;
                    end
                end

                WAIT_GAP: begin
                    if (r_gap_cnt == GAP_MAX) begin
                        r_state    <= START;
                        r_rd_start <= 1'b1;
                    end
                end

                START: begin
                    r_tmo_cnt <= '0;
                    r_state   <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (rd_done) begin
                        r_cap_hum  <= rd_data[39:32];
                        r_cap_temp <= rd_data[23:16];
                        r_state    <= CHECK;
                    end else if (r_tmo_cnt != TMO_LAST) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    if (w_pass) begin
                        r_state <= UPDATE;
                    end
                end

                UPDATE: begin
                    r_temp  <= r_cap_temp;
                    r_hum   <= r_cap_hum;
                    r_valid <= 1'b1;
                    r_upd   <= 1'b1;
                    r_retry <= '0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Shared failure path for timeouts and checksum rejects; published
            // values are deliberately left untouched here.
            if (w_attempt_fail) begin
                if (r_retry == RTY_MAX) begin
                    r_fail  <= 1'b1;
                    r_retry <= '0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (r_err != 8'hFF) begin
                        r_err <= r_err + 8'd1;
                    end
                end else begin
                    // Retry goes back through WAIT_GAP so the sensor gap still holds.
                    r_retry <= r_retry + 1'b1;
                    r_state <= WAIT_GAP;
                end
            end
        end
    end

    assign rd_start  = r_rd_start;
    assign temp      = r_temp;
    assign humidity  = r_hum;
    assign valid     = r_valid;
    assign upd       = r_upd;
    assign fail      = r_fail;
    assign err_count = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// Bench for dht_poll_scheduler with small timing parameters.
// A single thread drives requests, answers each rd_start as scripted per attempt,
// and compares the outcome of every read sequence with expected values.

module tb_dht_poll_scheduler;

    localparam int PER = 1000;
    localparam int GAP = 200;
    localparam int TMO = 100;
    localparam int MR  = 2;

`ifdef DHT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    localparam logic [39:0] GOOD1 = 40'h37001A0051;
    localparam logic [39:0] BAD1  = 40'h37001A0052;
    localparam logic [39:0] GOOD2 = 40'h2D0516034B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_manual = 1'b0;
    logic        rd_done = 1'b0;
    logic [39:0] rd_data = 40'd0;
    logic        rd_start;
    logic [7:0]  temp;
    logic [7:0]  humidity;
    logic        valid;
    logic        upd;
    logic        fail;
    logic [7:0]  err_count;
    logic        busy;

    always #5 clk = ~clk;

    dht_poll_scheduler #(
        .PERIOD_CYC (PER),
        .MIN_GAP_CYC(GAP),
        .TIMEOUT_CYC(TMO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_manual(req_manual),
        .rd_start  (rd_start),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .temp      (temp),
        .humidity  (humidity),
        .valid     (valid),
        .upd       (upd),
        .fail      (fail),
        .err_count (err_count),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Per-attempt reader behaviour: answer or stay silent, delay after rd_start, frame.
    bit          att_resp [3];
    int          att_dly  [3];
    logic [39:0] att_frm  [3];

    // Observed outcome of one sequence.
    int n_st;
    int st_cyc [8];
    int outc;      // 0 none, 1 upd, 2 fail
    int end_cyc;
    bit expired;

    task automatic run_seq(input int req1, input int req2, input int budget,
                           input bit stop_done, input int stop_after);
        int cyc     = 0;
        int cd      = 0;
        int idx     = 0;
        int last_st = 0;
        n_st    = 0;
        outc    = 0;
        end_cyc = 0;
        expired = 1'b1;
        for (int i = 0; i < 8; i++) st_cyc[i] = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rd_done) rd_done = 1'b0;
            req_manual = (cyc == req1) || (cyc == req2);
            if (upd && outc == 0) begin
                outc    = 1;
                end_cyc = cyc;
            end
            if (fail && outc == 0) begin
                outc    = 2;
                end_cyc = cyc;
            end
            if (stop_done && outc != 0) begin
                expired = 1'b0;
                break;
            end
            if (rd_start) begin
                idx = (n_st < 3) ? n_st : 2;
                if (n_st < 8) st_cyc[n_st] = cyc;
                last_st = cyc;
                n_st++;
                cd = att_resp[idx] ? att_dly[idx] : 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    rd_done = 1'b1;
                    rd_data = att_frm[idx];
                end
            end
            if (stop_after >= 0 && n_st > 0 && cyc == last_st + stop_after) begin
                expired = 1'b0;
                break;
            end
        end
        req_manual = 1'b0;
        rd_done    = 1'b0;
        if (stop_done) chk("seq_budget_expired", expired, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_manual = 1'b0;
        rd_done    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit ck_ok(input logic [39:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return !CK || (s == f[7:0]);
    endfunction

    // Starts of one sequence are at least GAP apart and not needlessly delayed.
    function automatic bit spacing_ok();
        bit ok = 1'b1;
        for (int i = 1; i < 3; i++) begin
            if (i < n_st) begin
                if (st_cyc[i] - st_cyc[i-1] < GAP || st_cyc[i] - st_cyc[i-1] > GAP + 5) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    typedef struct {
        logic [2:0]  r;
        int          d0, d1, d2;
        logic [39:0] f0, f1, f2;
        int          starts;
        int          oc;
        int          t;
        int          h;
        int          err;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int m_t, m_h, m_v, m_e, k, e_starts, e_oc, upd_seen;
        logic [7:0] b4, b3, b2, b1, b0;

        // ---------------- table of single-sequence scenarios (each after reset) ------------
        tbl[0] = '{3'b111, 5, 5, 5, GOOD1, GOOD1, GOOD1, 1, 1, 26, 55, 0};
        tbl[1] = CK ? '{3'b111, 5, 5, 5, BAD1, BAD1, BAD1, 3, 2, 0, 0, 1}
                    : '{3'b111, 5, 5, 5, BAD1, BAD1, BAD1, 1, 1, 26, 55, 0};
        tbl[2] = '{3'b000, 0, 0, 0, GOOD1, GOOD1, GOOD1, 3, 2, 0, 0, 1};
        tbl[3] = CK ? '{3'b111, 5, 5, 5, BAD1, GOOD2, GOOD2, 2, 1, 22, 45, 0}
                    : '{3'b111, 5, 5, 5, BAD1, GOOD2, GOOD2, 1, 1, 26, 55, 0};
        tbl[4] = '{3'b001, 100, 0, 0, GOOD1, GOOD1, GOOD1, 1, 1, 26, 55, 0};
        tbl[5] = '{3'b011, 101, 1, 0, GOOD1, GOOD2, GOOD2, 2, 1, 22, 45, 0};
        tbl[6] = '{3'b100, 0, 0, 50, GOOD1, GOOD1, GOOD2, 3, 1, 22, 45, 0};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("reset_outputs", {rd_start, temp, humidity, valid, upd, fail, err_count, busy}, 0);
        rst = 1'b0;

        // ---------------- first automatic read after reset release ----------------
        att_resp = '{1'b1, 1'b1, 1'b1};
        att_dly  = '{5, 5, 5};
        att_frm  = '{GOOD1, GOOD1, GOOD1};
        run_seq(-1, -1, 1300, 1'b1, -1);
        chk("auto_first_start_window", (st_cyc[0] >= PER && st_cyc[0] <= PER + 5) ? 1 : 0, 1);
        chk("auto_outcome", outc, 1);
        chk("auto_temp", temp, 26);
        chk("auto_hum", humidity, 55);
        chk("auto_valid", valid, 1);

        // ---------------- table-driven sequences ----------------
        for (int v = 0; v < 7; v++) begin
            do_reset();
            att_resp = '{tbl[v].r[0], tbl[v].r[1], tbl[v].r[2]};
            att_dly  = '{tbl[v].d0, tbl[v].d1, tbl[v].d2};
            att_frm  = '{tbl[v].f0, tbl[v].f1, tbl[v].f2};
            run_seq(10, -1, 1200, 1'b1, -1);
            chk($sformatf("v%0d_starts", v), n_st, tbl[v].starts);
            chk($sformatf("v%0d_outcome", v), outc, tbl[v].oc);
            chk($sformatf("v%0d_temp", v), temp, tbl[v].t);
            chk($sformatf("v%0d_hum", v), humidity, tbl[v].h);
            chk($sformatf("v%0d_valid", v), valid, (tbl[v].oc == 1) ? 1 : 0);
            chk($sformatf("v%0d_err", v), err_count, tbl[v].err);
            chk($sformatf("v%0d_busy_after", v), busy, 0);
            chk($sformatf("v%0d_first_start_min", v), (st_cyc[0] >= GAP) ? 1 : 0, 1);
            chk($sformatf("v%0d_spacing", v), spacing_ok(), 1);
            if (v == 2) chk("v2_timeout_end", end_cyc - st_cyc[2], TMO + 1);
        end

        // ---------------- coalescing: req at 10 and a second req at 50 ----------------
        do_reset();
        att_resp = '{1'b1, 1'b1, 1'b1};
        att_dly  = '{5, 5, 5};
        att_frm  = '{GOOD1, GOOD1, GOOD1};
        run_seq(10, 50, 390, 1'b0, -1);
        chk("coalesce_starts", n_st, 1);
        chk("coalesce_start_min", (st_cyc[0] >= GAP) ? 1 : 0, 1);
        chk("coalesce_upd", outc, 1);

        // ---------------- reset during WAIT_DONE, late rd_done ignored ----------------
        do_reset();
        run_seq(10, -1, 600, 1'b1, -1);
        chk("rst_mid_pre_valid", valid, 1);
        att_resp = '{1'b0, 1'b0, 1'b0};
        run_seq(1, -1, 600, 1'b0, 10);
        chk("rst_mid_started", n_st, 1);
        chk("rst_mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {rd_start, temp, humidity, valid, upd, fail, err_count, busy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_done = 1'b1;
        rd_data = GOOD1;
        @(negedge clk);
        rd_done  = 1'b0;
        upd_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (upd) upd_seen++;
        end
        chk("rst_late_done_upd", upd_seen, 0);
        chk("rst_late_done_valid", valid, 0);
        chk("rst_late_done_busy", busy, 0);

        // ---------------- randomized sequences driven by the period tick ----------------
        do_reset();
        m_t = 0; m_h = 0; m_v = 0; m_e = 0;
        for (int s = 0; s < 10; s++) begin
            for (int a = 0; a < 3; a++) begin
                att_resp[a] = ($urandom_range(0, 4) != 0);
                att_dly[a]  = $urandom_range(1, 110);
                b4 = 8'($urandom_range(0, 255));
                b3 = 8'($urandom_range(0, 255));
                b2 = 8'($urandom_range(0, 255));
                b1 = 8'($urandom_range(0, 255));
                b0 = ($urandom_range(0, 1) != 0) ? 8'(b4 + b3 + b2 + b1) : 8'($urandom_range(0, 255));
                att_frm[a] = {b4, b3, b2, b1, b0};
            end
            // Model: the first attempt that answers in time with an acceptable frame wins.
            k = -1;
            for (int a = 0; a < 3; a++) begin
                if (k < 0 && att_resp[a] && att_dly[a] <= TMO && ck_ok(att_frm[a])) k = a;
            end
            if (k >= 0) begin
                e_starts = k + 1;
                e_oc     = 1;
                m_t      = att_frm[k][23:16];
                m_h      = att_frm[k][39:32];
                m_v      = 1;
            end else begin
                e_starts = MR + 1;
                e_oc     = 2;
                m_e      = (m_e < 255) ? m_e + 1 : 255;
            end
            run_seq(-1, -1, 2200, 1'b1, -1);
            chk($sformatf("r%0d_starts", s), n_st, e_starts);
            chk($sformatf("r%0d_outcome", s), outc, e_oc);
            chk($sformatf("r%0d_temp", s), temp, m_t);
            chk($sformatf("r%0d_hum", s), humidity, m_h);
            chk($sformatf("r%0d_valid", s), valid, m_v);
            chk($sformatf("r%0d_err", s), err_count, m_e);
            chk($sformatf("r%0d_spacing", s), spacing_ok(), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
